fb_write_arbiter: RTL and testbench

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

---
 rtl/fb_write_arbiter.sv | 160 ++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: shares one registered framebuffer write port between CPU pixel writes
// and a full-buffer clear engine.
//
// Optional feature macro: FB_WRITE_ARBITER_CLEAR_EN
//   defined   - clear engine (Idle/Clear/Done sweep) plus round-robin arbitration
//   undefined - CPU owns the port outright; clr_start_i/clr_color_i are ignored and
//               clr_busy_o/clr_done_o are tied low
//
// Ports:
//   clk_i, rst_i                      clock; asynchronous active-high reset
//   cpu_req_i, cpu_addr_i, cpu_data_i CPU write request (held stable while requesting)
//   cpu_ack_o                         combinational grant for the CPU request
//   clr_start_i, clr_color_i          clear request pulse and fill value
//   clr_busy_o, clr_done_o            sweep in progress / one-cycle completion pulse
//   fb_we_o, fb_waddr_o, fb_din_o     registered framebuffer write port (1-cycle latency)
//
// DEPTH must not exceed 2**ADDR_W so the sweep counter never wraps.
module fb_write_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic              cpu_ack_o,
  input  logic              clr_start_i,
  input  logic [DATA_W-1:0] clr_color_i,
  output logic              clr_busy_o,
  output logic              clr_done_o,
  output logic              fb_we_o,
  output logic [ADDR_W-1:0] fb_waddr_o,
  output logic [DATA_W-1:0] fb_din_o
);

  // Granted write for this cycle, registered onto the framebuffer port below.
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

`ifdef FB_WRITE_ARBITER_CLEAR_EN
  typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] color_q, color_d;
  // 1 when the clear engine held the most recent grant; resets to 1 so the CPU wins
  // the first contention.
  logic              last_clr_q, last_clr_d;
  logic              clr_req;
  logic              cpu_gnt;
  logic              clr_gnt;

  assign clr_req = (state_q == StClear);

  // Lone requester always wins; under contention the one not granted last goes.
  assign cpu_gnt = ~rst_i & cpu_req_i & (~clr_req | last_clr_q);
  assign clr_gnt = ~rst_i & clr_req & (~cpu_req_i | ~last_clr_q);

  assign wr_en   = cpu_gnt | clr_gnt;
  assign wr_addr = clr_gnt ? cnt_q : cpu_addr_i;
  assign wr_data = clr_gnt ? color_q : cpu_data_i;

  assign cpu_ack_o  = cpu_gnt;
  assign clr_busy_o = (state_q == StClear);
  assign clr_done_o = (state_q == StDone);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    color_d    = color_q;
    last_clr_d = last_clr_q;

    if (cpu_gnt) begin
      last_clr_d = 1'b0;
    end else if (clr_gnt) begin
      last_clr_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (clr_start_i) begin
          state_d = StClear;
          cnt_d   = '0;
          color_d = clr_color_i;
        end
      end
      StClear: begin
        // Counter moves only when the engine actually wins the port.
        if (clr_gnt) begin
          if (cnt_q == LastAddr) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      color_q    <= '0;
      last_clr_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      color_q    <= color_d;
      last_clr_q <= last_clr_d;
    end
  end
`else
  assign wr_en   = cpu_req_i & ~rst_i;
  assign wr_addr = cpu_addr_i;
  assign wr_data = cpu_data_i;

  assign cpu_ack_o  = wr_en;
  assign clr_busy_o = 1'b0;
  assign clr_done_o = 1'b0;

  logic unused_clr;
  assign unused_clr = ^{clr_start_i, clr_color_i};
`endif

  // Address/data hold their last value when nothing is granted.
  logic              fb_we_q;
  logic [ADDR_W-1:0] fb_waddr_q;
  logic [DATA_W-1:0] fb_din_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fb_we_q    <= 1'b0;
      fb_waddr_q <= '0;
      fb_din_q   <= '0;
    end else begin
      fb_we_q <= wr_en;
      if (wr_en) begin
        fb_waddr_q <= wr_addr;
        fb_din_q   <= wr_data;
      end
    end
  end

  assign fb_we_o    = fb_we_q;
  assign fb_waddr_o = fb_waddr_q;
  assign fb_din_o   = fb_din_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter. A behavioural model tracks the sweep as
// "clearing / next address / fill colour / who was granted last" and predicts every
// cycle's outputs; scenario tasks compare the DUT against it and against directed values.
module tb_fb_write_arbiter;
  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 4;
  localparam int unsigned DEPTH = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_data = '0;
  logic          cpu_ack;
  logic          clr_start = 1'b0;
  logic [DW-1:0] clr_color = '0;
  logic          clr_busy;
  logic          clr_done;
  logic          fb_we;
  logic [AW-1:0] fb_waddr;
  logic [DW-1:0] fb_din;

  always #5 clk = ~clk;

  fb_write_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cpu_req_i  (cpu_req),
    .cpu_addr_i (cpu_addr),
    .cpu_data_i (cpu_data),
    .cpu_ack_o  (cpu_ack),
    .clr_start_i(clr_start),
    .clr_color_i(clr_color),
    .clr_busy_o (clr_busy),
    .clr_done_o (clr_done),
    .fb_we_o    (fb_we),
    .fb_waddr_o (fb_waddr),
    .fb_din_o   (fb_din)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  bit            m_clearing;   // sweep in progress
  bit            m_done;       // the one cycle after the final clear write
  bit            m_cpu_last;   // CPU held the most recent grant
  int            m_next;       // next address the sweep will write
  logic [DW-1:0] m_color;
  bit            g_cpu, g_clr; // who the model grants this cycle
  bit            x_we;         // expected framebuffer port this cycle
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_din;
  bit            p_req, p_start;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data, p_color;
  int            seen [DEPTH];

  function automatic void model_reset();
    m_clearing = 0; m_done = 0; m_cpu_last = 0; m_next = 0; m_color = '0;
    g_cpu = 0; g_clr = 0; x_we = 0; x_addr = '0; x_din = '0;
    p_req = 0; p_start = 0; p_addr = '0; p_data = '0; p_color = '0;
  endfunction

  // Effect of one rising edge, using the inputs/grants of the cycle just ended.
  function automatic void model_edge();
    x_we = g_cpu || g_clr;
    if (g_cpu) begin x_addr = p_addr; x_din = p_data; end
    if (g_clr) begin x_addr = AW'(m_next); x_din = m_color; end
    if (g_cpu) m_cpu_last = 1;
    else if (g_clr) m_cpu_last = 0;
    if (m_done) begin
      m_done = 0;
    end else if (m_clearing) begin
      if (g_clr) begin
        if (m_next == int'(DEPTH) - 1) begin m_clearing = 0; m_done = 1; end
        else m_next = m_next + 1;
      end
    end else if (p_start) begin
`ifdef FB_WRITE_ARBITER_CLEAR_EN
      m_clearing = 1; m_next = 0; m_color = p_color;
`endif
    end
  endfunction

  function automatic void model_grant();
    if (p_req && m_clearing) begin
      g_cpu = !m_cpu_last; g_clr = m_cpu_last;
    end else begin
      g_cpu = p_req; g_clr = m_clearing;
    end
  endfunction

  // One clock cycle: edge into the model, apply new inputs, predict grants.
  task automatic drive(input bit req, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit st, input logic [DW-1:0] col);
    @(negedge clk);
    model_edge();
    cpu_req = req; cpu_addr = a; cpu_data = d; clr_start = st; clr_color = col;
    p_req = req; p_addr = a; p_data = d; p_start = st; p_color = col;
    model_grant();
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    cpu_req = 0; clr_start = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; cpu_req = 1'b1; clr_start = 1'b1; cpu_addr = 12'h3C3; cpu_data = 4'h9;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (cpu_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", cpu_ack); end
      total++;
      if (fb_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", fb_we); end
      total++;
      if (fb_waddr !== '0) begin bad++; $display("FAIL reset_addr got=%h want=0", fb_waddr); end
      total++;
      if (fb_din !== '0) begin bad++; $display("FAIL reset_din got=%h want=0", fb_din); end
      total++;
      if ({clr_busy, clr_done} !== 2'b00) begin
        bad++; $display("FAIL reset_clr got busy/done=%b/%b want=0/0", clr_busy, clr_done);
      end
      repeat (2) @(negedge clk);
      #1;
    end
    rst = 1'b0; cpu_req = 0; clr_start = 0;
    model_reset();
  endtask

  task automatic test_cpu_only();
    drive(1, 12'h123, 4'hA, 0, 4'h0);
    total++;
    if (cpu_ack !== 1'b1) begin bad++; $display("FAIL cpu_only_ack got=%b want=1", cpu_ack); end
    drive(0, 12'h000, 4'h0, 0, 4'h0);
    total++;
    if ({fb_we, fb_waddr, fb_din} !== {1'b1, 12'h123, 4'hA}) begin
      bad++; $display("FAIL cpu_only_write got we/addr/din=%b/%h/%h want=1/123/a",
                      fb_we, fb_waddr, fb_din);
    end
    drive(0, 12'h000, 4'h0, 0, 4'h0);
    total++;
    if ({fb_we, fb_waddr, fb_din} !== {1'b0, 12'h123, 4'hA}) begin
      bad++; $display("FAIL cpu_only_hold got we/addr/din=%b/%h/%h want=0/123/a",
                      fb_we, fb_waddr, fb_din);
    end
  endtask

  task automatic test_random_cpu(input int cycles);
    bit st;
    for (int c = 0; c < cycles; c++) begin
      st = 0;
`ifndef FB_WRITE_ARBITER_CLEAR_EN
      st = ($urandom_range(0, 3) == 0);
`endif
      drive($urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom), st, DW'($urandom));
      total++;
      if ({cpu_ack, fb_we, fb_waddr, fb_din, clr_busy, clr_done} !==
          {g_cpu, x_we, x_addr, x_din, m_clearing, m_done}) begin
        bad++;
        $display("FAIL random_cpu c=%0d got ack/we/addr/din/busy/done=%b/%b/%h/%h/%b/%b want=%b/%b/%h/%h/%b/%b",
                 c, cpu_ack, fb_we, fb_waddr, fb_din, clr_busy, clr_done,
                 g_cpu, x_we, x_addr, x_din, m_clearing, m_done);
      end
    end
  endtask

`ifdef FB_WRITE_ARBITER_CLEAR_EN
  task automatic test_clear_only();
    int busy_n = 0, we_n = 0, done_n = 0, seq_err = 0, gap_n = 0, cyc = 0;
    bit seen_done = 0;
    drive(0, '0, '0, 1, 4'h5);
    while (!seen_done && cyc < int'(DEPTH) + 10) begin
      drive(0, '0, '0, 0, 4'h3);
      cyc++;
      total++;
      if ({cpu_ack, fb_we, fb_waddr, fb_din, clr_busy, clr_done} !==
          {g_cpu, x_we, x_addr, x_din, m_clearing, m_done}) begin
        bad++;
        $display("FAIL clear_only cyc=%0d got we/addr/din/busy/done=%b/%h/%h/%b/%b want=%b/%h/%h/%b/%b",
                 cyc, fb_we, fb_waddr, fb_din, clr_busy, clr_done,
                 x_we, x_addr, x_din, m_clearing, m_done);
      end
      if (clr_busy) busy_n++;
      if (fb_we) begin
        if (fb_waddr !== AW'(we_n) || fb_din !== 4'h5) seq_err++;
        we_n++;
      end else if (we_n > 0 && we_n < int'(DEPTH)) begin
        gap_n++;
      end
      if (clr_done) begin done_n++; seen_done = 1; end
    end
    repeat (3) begin
      drive(0, '0, '0, 0, 4'h0);
      if (clr_done) done_n++;
    end
    total++;
    if (!seen_done) begin bad++; $display("FAIL clear_only_timeout cycles=%0d limit=%0d", cyc, DEPTH + 10); end
    total++;
    if (busy_n != int'(DEPTH)) begin bad++; $display("FAIL clear_only_busy got=%0d want=%0d", busy_n, DEPTH); end
    total++;
    if (we_n != int'(DEPTH)) begin bad++; $display("FAIL clear_only_writes got=%0d want=%0d", we_n, DEPTH); end
    total++;
    if (seq_err != 0 || gap_n != 0) begin
      bad++; $display("FAIL clear_only_seq got errors=%0d gaps=%0d want=0/0", seq_err, gap_n);
    end
    total++;
    if (done_n != 1) begin bad++; $display("FAIL clear_only_done got=%0d want=1", done_n); end
  endtask

  // pct: probability (percent) that the CPU requests in any cycle of the sweep.
  task automatic test_contention(input int pct);
    int cyc = 0, done_cyc = -1, alt_err = 0, uncovered = 0;
    bit prev_valid = 0, prev_ack = 0, req;
    logic [DW-1:0] d;
    foreach (seen[i]) seen[i] = 0;
    drive(1, AW'($urandom), 4'h0, 1, 4'h5);
    while (done_cyc < 0 && cyc < 2 * int'(DEPTH) + 10) begin
      req = ($urandom_range(1, 100) <= pct);
      d = DW'($urandom_range(0, 14));
      if (d >= 4'h5) d = d + 4'h1;  // CPU data never equals the fill colour
      drive(req, AW'($urandom), d, 0, 4'h0);
      cyc++;
      total++;
      if ({cpu_ack, fb_we, fb_waddr, fb_din, clr_busy, clr_done} !==
          {g_cpu, x_we, x_addr, x_din, m_clearing, m_done}) begin
        bad++;
        $display("FAIL contention cyc=%0d got ack/we/addr/din/busy/done=%b/%b/%h/%h/%b/%b want=%b/%b/%h/%h/%b/%b",
                 cyc, cpu_ack, fb_we, fb_waddr, fb_din, clr_busy, clr_done,
                 g_cpu, x_we, x_addr, x_din, m_clearing, m_done);
      end
      if (fb_we && fb_din === 4'h5) seen[fb_waddr]++;
      if (clr_busy && req) begin
        if (prev_valid && cpu_ack == prev_ack && pct == 100) alt_err++;
        prev_valid = 1; prev_ack = cpu_ack;
      end
      if (clr_done) done_cyc = cyc;
    end
    foreach (seen[i]) if (seen[i] != 1) uncovered++;
    total++;
    if (done_cyc < 0 || done_cyc > 2 * int'(DEPTH) + 2) begin
      bad++; $display("FAIL contention_latency pct=%0d got=%0d want<=%0d", pct, done_cyc, 2 * DEPTH + 2);
    end
    total++;
    if (uncovered != 0) begin
      bad++; $display("FAIL contention_cover pct=%0d addrs_not_once=%0d want=0", pct, uncovered);
    end
    total++;
    if (alt_err != 0) begin bad++; $display("FAIL contention_alternate pct=%0d got=%0d want=0", pct, alt_err); end
  endtask

  task automatic test_ignored_start();
    int we_n = 0, col_err = 0, done_n = 0;
    bit st, last_write, hit_done = 0;
    logic [DW-1:0] col;
    drive(0, '0, '0, 1, 4'h9);
    last_write = 0;
    for (int c = 0; c < int'(DEPTH) + 20; c++) begin
      st = (c == 50); col = 4'h2;
      if (last_write) begin st = 1; col = 4'h7; end  // lands in the done cycle
      drive(0, '0, '0, st, col);
      last_write = g_clr && (m_next == int'(DEPTH) - 1);
      total++;
      if ({fb_we, fb_waddr, fb_din, clr_busy, clr_done} !==
          {x_we, x_addr, x_din, m_clearing, m_done}) begin
        bad++;
        $display("FAIL ignored_start c=%0d got we/addr/din/busy/done=%b/%h/%h/%b/%b want=%b/%h/%h/%b/%b",
                 c, fb_we, fb_waddr, fb_din, clr_busy, clr_done,
                 x_we, x_addr, x_din, m_clearing, m_done);
      end
      if (fb_we) begin we_n++; if (fb_din !== 4'h9) col_err++; end
      if (clr_done) begin done_n++; if (st) hit_done = 1; end
    end
    total++;
    if (we_n != int'(DEPTH) || col_err != 0) begin
      bad++; $display("FAIL ignored_start_writes got=%0d bad_colour=%0d want=%0d/0", we_n, col_err, DEPTH);
    end
    total++;
    if (done_n != 1 || !hit_done) begin
      bad++; $display("FAIL ignored_start_done got=%0d pulse_in_done=%b want=1/1", done_n, hit_done);
    end
    total++;
    if (clr_busy !== 1'b0) begin bad++; $display("FAIL ignored_start_idle got busy=%b want=0", clr_busy); end
  endtask

  task automatic test_reset_mid_clear();
    int cyc = 0;
    bit got_done = 0;
    drive(0, '0, '0, 1, 4'h6);
    while (!(g_clr && m_next == 100) && cyc < 200) begin
      drive(0, '0, '0, 0, 4'h0);
      cyc++;
    end
    total++;
    if (!(g_clr && m_next == 100)) begin bad++; $display("FAIL mid_clear_reach cycles=%0d", cyc); end
    cpu_req = 1'b1;
    rst = 1'b1;
    #1;
    total++;
    if ({cpu_ack, fb_we, fb_waddr, fb_din, clr_busy, clr_done} !== '0) begin
      bad++; $display("FAIL mid_clear_reset got ack/we/addr/din/busy/done=%b/%b/%h/%h/%b/%b want=all 0",
                      cpu_ack, fb_we, fb_waddr, fb_din, clr_busy, clr_done);
    end
    repeat (3) begin
      @(negedge clk);
      if (clr_done) got_done = 1;
    end
    rst = 1'b0; cpu_req = 1'b0;
    model_reset();
    drive(0, '0, '0, 0, 4'h0);
    if (clr_done) got_done = 1;
    total++;
    if (got_done) begin bad++; $display("FAIL mid_clear_done got=1 want=0"); end
    drive(0, '0, '0, 1, 4'hC);
    drive(0, '0, '0, 0, 4'h0);
    drive(0, '0, '0, 0, 4'h0);
    total++;
    if ({fb_we, fb_waddr, fb_din, clr_busy} !== {1'b1, 12'h000, 4'hC, 1'b1}) begin
      bad++; $display("FAIL mid_clear_restart got we/addr/din/busy=%b/%h/%h/%b want=1/000/c/1",
                      fb_we, fb_waddr, fb_din, clr_busy);
    end
    apply_reset();
  endtask
`else
  task automatic test_macro_off();
    int we_n = 0, ack_n = 0, clr_n = 0;
    drive(0, '0, '0, 1, 4'hF);
    repeat (4) begin
      drive(0, '0, '0, 0, 4'h0);
      if (fb_we || clr_busy || clr_done) clr_n++;
    end
    total++;
    if (clr_n != 0) begin bad++; $display("FAIL macro_off_clear got active_cycles=%0d want=0", clr_n); end
    for (int k = 0; k < 3; k++) begin
      drive(1, AW'(12'h200 + k), DW'(k + 1), 0, 4'h0);
      if (cpu_ack) ack_n++;
      if (fb_we) we_n++;
    end
    drive(0, '0, '0, 0, 4'h0);
    if (fb_we) we_n++;
    total++;
    if (ack_n != 3) begin bad++; $display("FAIL macro_off_acks got=%0d want=3", ack_n); end
    total++;
    if (we_n != 3) begin bad++; $display("FAIL macro_off_writes got=%0d want=3", we_n); end
    total++;
    if ({fb_waddr, fb_din} !== {12'h202, 4'h3}) begin
      bad++; $display("FAIL macro_off_last got addr/din=%h/%h want=202/3", fb_waddr, fb_din);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_cpu_only();
    test_random_cpu(300);
`ifdef FB_WRITE_ARBITER_CLEAR_EN
    test_clear_only();
    test_contention(100);
    test_contention(50);
    test_ignored_start();
    test_reset_mid_clear();
    test_random_cpu(100);
`else
    test_macro_off();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
